cluster_primary_sequencer: RTL
==============================

Name: cluster_primary_sequencer

Overview:
Controller that drains one partition of cluster primaries (valid-pad flags plus per-key consecutive counts) into a serial stream of clusters, one per clock.
- Sits directly after the primary finder, one instance per partition row, and feeds the cluster packer.
- Each frame is captured on a start strobe, then the lowest-address primary is extracted every cycle.
- Extraction stops when the frame is empty or MXCLUSTERS have been emitted; leftover primaries are flagged as overflow.

Parameters:
MXKEYS, 192, pads per partition (width of vpfs_in)
MXCNTBITS, 3, bits per consecutive-count field
MXCLUSTERS, 8, maximum clusters emitted per frame
MXADRBITS, 8, cluster address width; must satisfy 2**MXADRBITS >= MXKEYS
MXIDXBITS, 3, cluster index width; must satisfy 2**MXIDXBITS >= MXCLUSTERS

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  capture frame; accepted only when busy=0
vpfs_in  input  MXKEYS  valid-pad flags; bit k = cluster starts at key k
cnts_in  input  MXKEYS*MXCNTBITS  per-key count; key k at [(k+1)*MXCNTBITS-1 : k*MXCNTBITS]
busy  output  1  frame in progress (state != IDLE)
cluster_valid  output  1  cluster_adr/cnt/idx valid this cycle
cluster_adr  output  MXADRBITS  key address of emitted cluster
cluster_cnt  output  MXCNTBITS  count field captured for that key
cluster_idx  output  MXIDXBITS  emission order within frame, 0-based
done  output  1  one-cycle end-of-frame pulse
overflow  output  1  valid with done; 1 = primaries remained after MXCLUSTERS emitted

Behaviour:
- Reset (sync, active-high): state=IDLE; working mask, count store, emitted counter cleared. busy, cluster_valid, cluster_adr, cluster_cnt, cluster_idx, done and overflow are all 0.
- Reset has priority over every other input. Reset mid-frame abandons the frame with no done pulse; outputs are 0 on the cycle after reset is sampled.
- States are IDLE, SCAN and DONE. busy=1 in SCAN and DONE. done=1 only in DONE. overflow is held at 0 outside DONE.
- IDLE:
  - start=1 at edge 0 latches vpfs_in into the working mask and cnts_in into the count store.
  - Emitted counter n is set to 0; state goes to SCAN (cycle 1).
  - start=0: stay in IDLE.
- SCAN, each cycle:
  - If n==MXCLUSTERS or the mask is all zero: go to DONE. overflow_next = (mask != 0). Nothing is emitted.
  - Otherwise: priority-encode the lowest set bit k. Register cluster_valid=1, cluster_adr=k, cluster_cnt=count[k], cluster_idx=n; these appear next cycle. Clear mask bit k; n increments.
- DONE: lasts exactly one cycle, then IDLE. busy drops the following cycle.
- Timing for a frame with k emitted clusters (k <= MXCLUSTERS), start sampled at edge 0:
  - cluster_valid=1 on cycles 2..k+1, contiguous, with idx 0..k-1 in ascending address order.
  - done on cycle k+2; busy on cycles 1..k+2; new start accepted from cycle k+3.
- Empty frame: done on cycle 2, overflow=0, no cluster_valid.
- cluster_valid deasserts the cycle after the last emission. cluster_adr/cnt/idx hold their last values when cluster_valid=0.
- start while busy=1 is ignored, and vpfs_in/cnts_in changes during a frame have no effect, because the frame is fully captured at start.
- Key 0 and key MXKEYS-1 are legal addresses; no wrap-around.
- Counter n saturates logically at MXCLUSTERS; cluster_idx never exceeds MXCLUSTERS-1.
- Count-store bits are copied unchanged; no arithmetic is applied.

Optional Feature:
CLUSTER_SEQ_MSB_FIRST_EN
- Defined: the priority encoder selects the highest set bit, so clusters are emitted in descending address order. Under overflow, the highest-address primaries are kept and the lowest are dropped.
- Undefined (default): lowest-address-first, as in Behaviour.
- Timing, handshake and overflow rules are identical in both builds.

Test Plan:
- Reset then start with vpfs_in bit 37 set and count[37]=5 -> cycle 2: valid, adr=37, cnt=5, idx=0; cycle 3: done=1, overflow=0; cycle 4: busy=0.
- Start with vpfs_in all zero -> no cluster_valid; done=1, overflow=0 on cycle 2.
- Start with bits 0, 191, 100 set -> adr 0, 100, 191 on cycles 2-4 (idx 0-2); done on cycle 5. With CLUSTER_SEQ_MSB_FIRST_EN: adr 191, 100, 0.
- Start with 10 primaries at keys 10,20,...,100 -> 8 clusters, adr 10..80, on cycles 2-9; done plus overflow=1 on cycle 10.
- Start at cycle 0, second start with different vpfs_in at cycle 3 -> ignored; output matches the first frame only. A start at cycle k+3 after done is accepted.
- Reset asserted during cycle 3 of a 6-cluster frame -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent start runs a clean frame.

Source files
------------

// File: rtl/cluster_primary_sequencer.sv
// Drains one captured frame of cluster primaries into a one-per-clock cluster stream; 2-cycle start-to-first-cluster latency.
// No backpressure: start is ignored while busy; optional CLUSTER_SEQ_MSB_FIRST_EN emits highest address first.
module cluster_primary_sequencer #(
    parameter int MXKEYS     = 192,
    parameter int MXCNTBITS  = 3,
    parameter int MXCLUSTERS = 8,
    parameter int MXADRBITS  = 8,
    parameter int MXIDXBITS  = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MXKEYS-1:0]           vpfs_in,
    input  logic [MXKEYS*MXCNTBITS-1:0] cnts_in,
    output logic                        busy,
    output logic                        cluster_valid,
    output logic [MXADRBITS-1:0]        cluster_adr,
    output logic [MXCNTBITS-1:0]        cluster_cnt,
    output logic [MXIDXBITS-1:0]        cluster_idx,
    output logic                        done,
    output logic                        overflow
);

    // One extra bit so the emitted counter can reach MXCLUSTERS itself.
    localparam int NW = MXIDXBITS + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [MXKEYS-1:0]             mask;
    logic [MXKEYS*MXCNTBITS-1:0]   cnts_q;
    logic [NW-1:0]                 n;
    logic                          found;
    logic [MXADRBITS-1:0]          sel_adr;
    logic [MXCNTBITS-1:0]          sel_cnt;
    logic                          frame_end;

    // Priority encoder: first set bit in scan order wins.
    always_comb begin
        found   = 1'b0;
        sel_adr = '0;
        sel_cnt = '0;
`ifdef CLUSTER_SEQ_MSB_FIRST_EN
        for (int i = MXKEYS - 1; i >= 0; i--) begin
`else
        for (int i = 0; i < MXKEYS; i++) begin
`endif
            if (mask[i] && !found) begin
                found   = 1'b1;
                sel_adr = MXADRBITS'(i);
                sel_cnt = cnts_q[i*MXCNTBITS +: MXCNTBITS];
            end
        end
    end

    assign frame_end = (n == NW'(MXCLUSTERS)) || !found;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (frame_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            cnts_q        <= '0;
            n             <= '0;
            cluster_valid <= 1'b0;
            cluster_adr   <= '0;
            cluster_cnt   <= '0;
            cluster_idx   <= '0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cluster_valid <= 1'b0;
            overflow      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask   <= vpfs_in;
                        cnts_q <= cnts_in;
                        n      <= '0;
                    end
                end
                SCAN: begin
                    if (frame_end) begin
                        // Anything still in the mask here was dropped by the cluster limit.
                        overflow <= |mask;
                    end else begin
                        cluster_valid <= 1'b1;
                        cluster_adr   <= sel_adr;
                        cluster_cnt   <= sel_cnt;
                        cluster_idx   <= n[MXIDXBITS-1:0];
                        mask          <= mask & ~(MXKEYS'(1) << sel_adr);
                        n             <= n + NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
